spatz_simd_sequencer: RTL and testbench
=======================================

SPATZ_SIMD_SEQUENCER -- requirements
Module: spatz_simd_sequencer

Interface
REQ-001 SHALL have parameter LaneWidth, default 64, giving lane data width in bits (a power of two, at least 32).
REQ-002 SHALL have parameter IdWidth, default 3, giving the instruction tag width.
REQ-003 SHALL have these ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
REQ-004 SHALL have these instruction issue ports:
- issue_valid_i  in  1  instruction valid
- issue_ready_o  out  1  sequencer can accept an instruction
- issue_op_i  in  op_e  operation
- issue_sew_i  in  rvv_pkg::vew_e  element width
- issue_signed_i  in  1  signed operation
- issue_vl_i  in  16  element count
- issue_id_i  in  IdWidth  instruction tag
REQ-005 SHALL have these operand ports:
- opd_valid_i  in  1  operand beat valid
- opd_ready_o  out  1  operand beat accepted
- opd_s1_i, opd_s2_i, opd_d_i  in  LaneWidth  operands
REQ-006 SHALL have these SIMD lane drive ports:
- lane_op_o  out  op_e  operation
- lane_sew_o  out  vew_e  element width
- lane_signed_o  out  1  signed operation
- lane_s1_o, lane_s2_o, lane_d_o  out  LaneWidth  operands
- lane_result_i  in  LaneWidth  combinational lane result
REQ-007 SHALL have these result ports:
- res_valid_o  out  1  result beat valid
- res_ready_i  in  1  result beat accepted
- res_data_o  out  LaneWidth  result data
- res_be_o  out  LaneWidth/8  byte enable
- res_last_o  out  1  final beat of the instruction
- res_id_o  out  IdWidth  instruction tag
REQ-008 SHALL have these status ports:
- done_o  out  1  one-cycle completion pulse
- done_id_o  out  IdWidth  tag of the completed instruction
- busy_o  out  1  state not IDLE

Function
REQ-009 SHALL implement states IDLE, RUN and DRAIN.
REQ-010 SHALL drive issue_ready_o=1 only in IDLE; an issue handshake latches op, sew, signed and id, and loads remaining-bytes counter = vl << sew (19 bits).
REQ-011 On issue with vl=0, SHALL stay in IDLE, produce no result beat, and pulse done_o with done_id_o=issue_id_i on the next cycle.
REQ-012 On issue with vl>0, SHALL go to RUN.
REQ-013 SHALL drive lane_op_o, lane_sew_o and lane_signed_o from the latched values.
REQ-014 SHALL pass lane_s1_o, lane_s2_o and lane_d_o combinationally from the opd_* inputs.
REQ-015 SHALL assert opd_ready_o = (state==RUN) && (!res_valid_o || res_ready_i); one operand beat is accepted per handshake.
REQ-016 On an operand handshake, SHALL register lane_result_i into res_data_o, giving 1-cycle latency from operand accept to res_valid_o.
REQ-017 On an operand handshake, SHALL register res_id_o and set res_be_o: all ones if remaining >= LaneWidth/8, else the low "remaining" bits set.
REQ-018 On an operand handshake, SHALL set res_last_o=1 iff remaining <= LaneWidth/8, then decrement remaining by min(remaining, LaneWidth/8).
REQ-019 SHALL go RUN->DRAIN when the last operand beat is accepted.
REQ-020 SHALL go DRAIN->IDLE on the result handshake of the last beat, pulsing done_o for one cycle in that same cycle with done_id_o set to the latched id.
REQ-021 SHALL clear res_valid_o on a result handshake with no simultaneous operand handshake.
REQ-022 On a simultaneous result and operand handshake, SHALL load the new beat with res_valid_o held at 1, with no bubble.
REQ-023 SHALL hold res_data_o, res_be_o, res_last_o and res_id_o stable while res_valid_o=1 and res_ready_i=0.
REQ-024 SHALL ignore opd_valid_i outside RUN and SHALL ignore issue_valid_i outside IDLE.
REQ-025 SHALL treat the element count as opaque; SIMD packing inside a beat belongs to the lane.
REQ-026 SHALL sustain full throughput of one beat per cycle when opd_valid_i=res_ready_i=1.

Reset
REQ-027 When rst_i=1 on a rising edge, including mid-instruction, SHALL force state=IDLE and remaining=0.
REQ-028 When rst_i=1 on a rising edge, SHALL force res_valid_o, res_last_o and done_o to 0, and res_data_o, res_be_o, res_id_o, done_id_o and the latched op/sew/id to 0.
REQ-029 SHALL produce outputs after reset of issue_ready_o=1, opd_ready_o=0 and busy_o=0; any in-flight beat is discarded with no done_o.

Verification
REQ-030 SHALL cover: VADD, sew=8b, vl=16, opd_valid and res_ready held at 1 -> 2 result beats on consecutive cycles, res_be_o=0xFF both, res_last_o only on beat 2, done_o pulses with beat 2 handshake.
REQ-031 SHALL cover: sew=32b, vl=3 -> 2 beats, res_be_o=0xFF then 0x0F, res_last_o=1 on beat 2.
REQ-032 SHALL cover: res_ready_i=0 for 3 cycles after the first beat -> opd_ready_o=0 and res_data_o stable for those cycles; the second beat appears the cycle after res_ready_i returns to 1.
REQ-033 SHALL cover: issue with vl=0, id=5 -> no res_valid_o; done_o=1 and done_id_o=5 exactly one cycle later; issue_ready_o stays 1.
REQ-034 SHALL cover: rst_i=1 during RUN with res_valid_o=1 -> next cycle res_valid_o=0, busy_o=0, issue_ready_o=1, and no done_o.
REQ-035 SHALL cover: issue_valid_i=1 while in RUN -> issue_ready_o=0 and no handshake until done_o has pulsed.

Source files
------------

// File: rtl/spatz_simd_sequencer.sv
// SIMD lane sequencer: splits one vector instruction into lane-wide beats,
// drives a combinational lane and streams registered results with byte enables.
package rvv_pkg;
  typedef enum logic [1:0] {
    EW_8,
    EW_16,
    EW_32,
    EW_64
  } vew_e;

  typedef enum logic [3:0] {
    VADD,
    VSUB,
    VMIN,
    VMAX,
    VAND,
    VOR,
    VXOR,
    VSLL,
    VSRL,
    VSRA,
    VMUL
  } op_e;
endpackage

module spatz_simd_sequencer
  import rvv_pkg::*;
#(
  parameter int unsigned LaneWidth = 64,
  parameter int unsigned IdWidth   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  op_e                    issue_op_i,
  input  vew_e                   issue_sew_i,
  input  logic                   issue_signed_i,
  input  logic [15:0]            issue_vl_i,
  input  logic [IdWidth-1:0]     issue_id_i,
  input  logic                   opd_valid_i,
  output logic                   opd_ready_o,
  input  logic [LaneWidth-1:0]   opd_s1_i,
  input  logic [LaneWidth-1:0]   opd_s2_i,
  input  logic [LaneWidth-1:0]   opd_d_i,
  output op_e                    lane_op_o,
  output vew_e                   lane_sew_o,
  output logic                   lane_signed_o,
  output logic [LaneWidth-1:0]   lane_s1_o,
  output logic [LaneWidth-1:0]   lane_s2_o,
  output logic [LaneWidth-1:0]   lane_d_o,
  input  logic [LaneWidth-1:0]   lane_result_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [LaneWidth-1:0]   res_data_o,
  output logic [LaneWidth/8-1:0] res_be_o,
  output logic                   res_last_o,
  output logic [IdWidth-1:0]     res_id_o,
  output logic                   done_o,
  output logic [IdWidth-1:0]     done_id_o,
  output logic                   busy_o
);

  localparam int unsigned BeW = LaneWidth / 8;
  localparam logic [18:0] BeatBytes = 19'(BeW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [18:0]          rem_q, rem_d;
  op_e                  op_q, op_d;
  vew_e                 sew_q, sew_d;
  logic                 signed_q, signed_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic                 res_valid_q, res_valid_d;
  logic [LaneWidth-1:0] res_data_q, res_data_d;
  logic [BeW-1:0]       res_be_q, res_be_d;
  logic                 res_last_q, res_last_d;
  logic [IdWidth-1:0]   res_id_q, res_id_d;
  logic                 done_q, done_d;
  logic [IdWidth-1:0]   done_id_q, done_id_d;

  logic           issue_hs, opd_hs, res_hs;
  logic           beat_last, drain_done;
  logic [BeW-1:0] be_tail;

  assign issue_ready_o = (state_q == IDLE);
  assign opd_ready_o   = (state_q == RUN) && (!res_valid_q || res_ready_i);
  assign busy_o        = (state_q != IDLE);

  assign issue_hs = issue_valid_i && issue_ready_o;
  assign opd_hs   = opd_valid_i && opd_ready_o;
  assign res_hs   = res_valid_q && res_ready_i;

  assign lane_op_o     = op_q;
  assign lane_sew_o    = sew_q;
  assign lane_signed_o = signed_q;
  assign lane_s1_o     = opd_s1_i;
  assign lane_s2_o     = opd_s2_i;
  assign lane_d_o      = opd_d_i;

  assign beat_last = (rem_q <= BeatBytes);

  always_comb begin
    for (int i = 0; i < BeW; i++) begin
      be_tail[i] = (19'(i) < rem_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    op_d        = op_q;
    sew_d       = sew_q;
    signed_d    = signed_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_be_d    = res_be_q;
    res_last_d  = res_last_q;
    res_id_d    = res_id_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    drain_done  = 1'b0;

    if (res_hs) res_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (issue_hs) begin
          op_d     = issue_op_i;
          sew_d    = issue_sew_i;
          signed_d = issue_signed_i;
          id_d     = issue_id_i;
          rem_d    = {3'b000, issue_vl_i} << issue_sew_i;
          if (issue_vl_i == 16'd0) begin
            done_d    = 1'b1;
            done_id_d = issue_id_i;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (opd_hs) begin
          res_valid_d = 1'b1;
          res_data_d  = lane_result_i;
          res_be_d    = beat_last ? be_tail : '1;
          res_last_d  = beat_last;
          res_id_d    = id_q;
          rem_d       = rem_q - (beat_last ? rem_q : BeatBytes);
          if (beat_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Completion is reported in the same cycle the last beat leaves.
        if (res_hs && res_last_q) begin
          state_d    = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      op_q        <= VADD;
      sew_q       <= EW_8;
      signed_q    <= 1'b0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_be_q    <= '0;
      res_last_q  <= 1'b0;
      res_id_q    <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      sew_q       <= sew_d;
      signed_q    <= signed_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_be_q    <= res_be_d;
      res_last_q  <= res_last_d;
      res_id_q    <= res_id_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_be_o    = res_be_q;
  assign res_last_o  = res_last_q;
  assign res_id_o    = res_id_q;
  assign done_o      = done_q | drain_done;
  assign done_id_o   = drain_done ? id_q : done_id_q;

endmodule

// File: tb/tb_spatz_simd_sequencer.sv
// Directed bench for spatz_simd_sequencer with an adder standing in for the lane.
module tb_spatz_simd_sequencer;
  import rvv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  op_e         issue_op = VADD;
  vew_e        issue_sew = EW_8;
  logic        issue_signed = 1'b0;
  logic [15:0] issue_vl = '0;
  logic [2:0]  issue_id = '0;
  logic        opd_valid = 1'b0;
  logic        opd_ready;
  logic [63:0] s1 = '0, s2 = '0, d = '0;
  op_e         lane_op;
  vew_e        lane_sew;
  logic        lane_signed;
  logic [63:0] lane_s1, lane_s2, lane_d, lane_result;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic [7:0]  res_be;
  logic        res_last;
  logic [2:0]  res_id;
  logic        done;
  logic [2:0]  done_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  assign lane_result = lane_s1 + lane_s2;

  spatz_simd_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_op_i(issue_op), .issue_sew_i(issue_sew),
    .issue_signed_i(issue_signed), .issue_vl_i(issue_vl),
    .issue_id_i(issue_id),
    .opd_valid_i(opd_valid), .opd_ready_o(opd_ready),
    .opd_s1_i(s1), .opd_s2_i(s2), .opd_d_i(d),
    .lane_op_o(lane_op), .lane_sew_o(lane_sew),
    .lane_signed_o(lane_signed),
    .lane_s1_o(lane_s1), .lane_s2_o(lane_s2), .lane_d_o(lane_d),
    .lane_result_i(lane_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_be_o(res_be),
    .res_last_o(res_last), .res_id_o(res_id),
    .done_o(done), .done_id_o(done_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input vew_e sew, input logic [15:0] vl,
                       input logic [2:0] id);
    issue_valid = 1'b1;
    issue_op    = VADD;
    issue_sew   = sew;
    issue_vl    = vl;
    issue_id    = id;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_issue_ready", 64'(issue_ready), 1);
    chk("rst_opd_ready", 64'(opd_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_res_valid", 64'(res_valid), 0);
    chk("rst_done", 64'(done), 0);
    rst = 1'b0;
    tick();

    // sew=8b vl=16: two full beats at full throughput
    issue(EW_8, 16'd16, 3'd1);
    s1 = 64'h0102030405060708;
    s2 = 64'h1010101010101010;
    d  = 64'hdeadbeefcafef00d;
    opd_valid = 1'b1;
    res_ready = 1'b1;
    chk("t1_issue_ready", 64'(issue_ready), 1);
    tick();
    issue_valid = 1'b0;
    chk("t1_busy", 64'(busy), 1);
    chk("t1_issue_ready_run", 64'(issue_ready), 0);
    chk("t1_opd_ready", 64'(opd_ready), 1);
    chk("t1_lane_op", 64'(lane_op), 64'(VADD));
    chk("t1_lane_sew", 64'(lane_sew), 64'(EW_8));
    chk("t1_lane_d", lane_d, 64'hdeadbeefcafef00d);
    tick();
    chk("t1_b1_valid", 64'(res_valid), 1);
    chk("t1_b1_data", res_data, 64'h1112131415161718);
    chk("t1_b1_be", 64'(res_be), 64'hff);
    chk("t1_b1_last", 64'(res_last), 0);
    chk("t1_b1_id", 64'(res_id), 1);
    chk("t1_b1_done", 64'(done), 0);
    s1 = 64'h00000000000000ff;
    tick();
    opd_valid = 1'b0;
    chk("t1_b2_valid", 64'(res_valid), 1);
    chk("t1_b2_data", res_data, 64'h101010101010110f);
    chk("t1_b2_be", 64'(res_be), 64'hff);
    chk("t1_b2_last", 64'(res_last), 1);
    chk("t1_b2_done", 64'(done), 1);
    chk("t1_b2_done_id", 64'(done_id), 1);
    tick();
    chk("t1_end_valid", 64'(res_valid), 0);
    chk("t1_end_done", 64'(done), 0);
    chk("t1_end_idle", 64'(issue_ready), 1);

    // sew=32b vl=3: 12 bytes, partial tail beat
    issue(EW_32, 16'd3, 3'd2);
    opd_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    tick();
    chk("t2_b1_be", 64'(res_be), 64'hff);
    chk("t2_b1_last", 64'(res_last), 0);
    tick();
    opd_valid = 1'b0;
    chk("t2_b2_valid", 64'(res_valid), 1);
    chk("t2_b2_be", 64'(res_be), 64'h0f);
    chk("t2_b2_last", 64'(res_last), 1);
    chk("t2_b2_done", 64'(done), 1);
    chk("t2_b2_done_id", 64'(done_id), 2);
    tick();
    chk("t2_end_busy", 64'(busy), 0);

    // backpressure: res_ready low for 3 cycles after first beat
    issue(EW_8, 16'd16, 3'd3);
    s1 = 64'h1;
    opd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    issue_valid = 1'b0;
    res_ready = 1'b0;
    tick();
    s1 = 64'h2;
    for (int k = 0; k < 3; k++) begin
      chk("t3_stall_opd_ready", 64'(opd_ready), 0);
      chk("t3_stall_valid", 64'(res_valid), 1);
      chk("t3_stall_data", res_data, 64'h1010101010101011);
      chk("t3_stall_be", 64'(res_be), 64'hff);
      chk("t3_stall_last", 64'(res_last), 0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("t3_resume_opd_ready", 64'(opd_ready), 1);
    tick();
    opd_valid = 1'b0;
    chk("t3_b2_valid", 64'(res_valid), 1);
    chk("t3_b2_data", res_data, 64'h1010101010101012);
    chk("t3_b2_last", 64'(res_last), 1);
    chk("t3_b2_done", 64'(done), 1);
    tick();

    // vl=0: immediate completion, no beats
    issue(EW_8, 16'd0, 3'd5);
    chk("t4_issue_ready", 64'(issue_ready), 1);
    tick();
    issue_valid = 1'b0;
    chk("t4_done", 64'(done), 1);
    chk("t4_done_id", 64'(done_id), 5);
    chk("t4_res_valid", 64'(res_valid), 0);
    chk("t4_issue_ready_after", 64'(issue_ready), 1);
    chk("t4_busy", 64'(busy), 0);
    tick();
    chk("t4_done_once", 64'(done), 0);

    // reset mid-instruction with a pending result
    issue(EW_8, 16'd16, 3'd3);
    opd_valid = 1'b1;
    res_ready = 1'b0;
    tick();
    issue_valid = 1'b0;
    tick();
    chk("t5_pre_valid", 64'(res_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    opd_valid = 1'b0;
    chk("t5_valid", 64'(res_valid), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_issue_ready", 64'(issue_ready), 1);
    chk("t5_opd_ready", 64'(opd_ready), 0);
    chk("t5_done", 64'(done), 0);
    chk("t5_data", res_data, 0);
    tick();
    chk("t5_no_late_done", 64'(done), 0);

    // issue while busy is held off until completion
    res_ready = 1'b1;
    issue(EW_8, 16'd16, 3'd4);
    tick();
    issue(EW_8, 16'd0, 3'd6);
    chk("t6_issue_ready_run", 64'(issue_ready), 0);
    opd_valid = 1'b1;
    tick();
    chk("t6_b1_issue_ready", 64'(issue_ready), 0);
    chk("t6_b1_done", 64'(done), 0);
    tick();
    opd_valid = 1'b0;
    chk("t6_b2_done", 64'(done), 1);
    chk("t6_b2_done_id", 64'(done_id), 4);
    tick();
    chk("t6_idle_done", 64'(done), 0);
    chk("t6_idle_ready", 64'(issue_ready), 1);
    tick();
    issue_valid = 1'b0;
    chk("t6_second_done", 64'(done), 1);
    chk("t6_second_done_id", 64'(done_id), 6);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
